// File: rtl/countup_debounced.sv
// countup_debounced: button-driven up-counter with a two-flop synchroniser,
// a stable-level debouncer, rising-edge press detection and a two-digit
// seven-segment readout of the count.
module countup_debounced #(
    parameter int N               = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit WRAP            = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         increase,
    input  logic         clear,
    output logic [N-1:0] count,
    output logic         full,
    output logic [6:0]   d0,
    output logic [6:0]   d1
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0]  MAX  = '1;

    logic [1:0]    sync_q;   // [0] = s1, [1] = s2
    logic          s2;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] deb_cnt;
    logic          inc_pulse;
    logic [3:0]    hi_nib;

    assign s2 = sync_q[1];

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], increase};
    end

    // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (s2 == deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == LAST) begin
            deb     <= s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) deb_q <= 1'b0;
        else       deb_q <= deb;
    end

    assign inc_pulse = deb & ~deb_q;

    // Count register: clear wins, then a press advances with saturate or wrap at MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc_pulse) begin
            if (count != MAX) count <= count + 1'b1;
            else if (WRAP)    count <= '0;
        end
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign hi_nib = 4'(count[N-1:4]);
    assign full   = (count == MAX);
    assign d0     = seg7(count[3:0]);
    assign d1     = seg7(hi_nib);

endmodule
